// File: rtl/cpu_types_pkg.sv
// Shared types for the RAM arbiter: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; slave = arbiter, master = environment.
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    word_t [NREQ-1:0]       req_addr;
    word_t [NREQ-1:0]       req_store;
    logic [NREQ-1:0]        req_wait;
    word_t                  req_load;

    logic                   ramREN;
    logic                   ramWEN;
    word_t                  ramaddr;
    word_t                  ramstore;
    word_t                  ramload;
    ramstate_t              ramstate;

    logic [IW-1:0]          owner;
    logic                   busy;
    logic                   err;

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, owner, busy, err
    );

    modport master (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, owner, busy, err
    );

endinterface

// File: rtl/ram_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);
    int j;

    // Scan from the far end so the candidate nearest ptr is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j[IW-1:0]]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// Define RAM_ARB_TIMEOUT_EN to abort a grant stalled for TIMEOUT cycles; err is registered (pulses the cycle after the abort).
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RST,
    ram_arbiter_if.slave        bus
);
    localparam int IW = idx_w(NREQ);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("ram_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_t        state;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     next_ptr;
    logic [IW-1:0]     sel_idx;
    logic              sel_vld;
    logic              busy_q;
    logic              err_q;
    logic [NREQ-1:0]   any_req;
    logic              own_ren, own_wen, own_req;
    logic              done, abort, leave, tmo;
    logic              ram_ren, ram_wen;
    logic [NREQ-1:0]   wait_v;

    assign any_req = bus.req_ren | bus.req_wen;

    rr_select #(.N(NREQ), .IW(IW)) u_sel (
        .req (any_req),
        .ptr (rr_ptr),
        .vld (sel_vld),
        .idx (sel_idx)
    );

    assign own_ren  = bus.req_ren[owner_q];
    assign own_wen  = bus.req_wen[owner_q];
    assign own_req  = own_ren | own_wen;
    assign done     = own_req && (bus.ramstate == ACCESS);
    assign abort    = own_req && !done && ((bus.ramstate == ERROR) || tmo);
    assign leave    = !own_req || done || abort;
    assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT);
    logic [TW-1:0] tcnt;
    assign tmo = (tcnt == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            owner_q <= '0;
            rr_ptr  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        owner_q <= sel_idx;
                        state   <= GRANT;
                        busy_q  <= 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (leave) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rr_ptr <= next_ptr;
                        err_q  <= abort;
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enables and the completion strobe follow the owner's live request and RAM state.
    always_comb begin
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        wait_v  = '1;
        if (state == GRANT && own_req) begin
            ram_wen = own_wen;
            ram_ren = own_ren & ~own_wen;
            if (done) wait_v[owner_q] = 1'b0;
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = bus.req_addr[owner_q];
    assign bus.ramstore = bus.req_store[owner_q];
    assign bus.req_wait = wait_v;
    assign bus.req_load = bus.ramload;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, latency, fairness, write priority, error, withdraw, timeout.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wexp;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
        cyc();
        cyc();
        rst = 1'b0;
        smp();
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wait", bus.req_wait, 4'hF);
        chk("rst_ren", bus.ramREN, 0);
        chk("rst_owner", bus.owner, 0);

        // Reset held two cycles in the middle of a grant
        cyc();
        bus.req_ren[3] = 1'b1;
        bus.ramstate   = BUSY;
        smp();
        chk("mid_idle_wait", bus.req_wait, 4'hF);
        cyc();
        smp();
        chk("mid_busy", bus.busy, 1);
        chk("mid_owner", bus.owner, 3);
        chk("mid_ren", bus.ramREN, 1);
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        bus.req_ren = '0;
        smp();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_owner", bus.owner, 0);
        chk("mid_rst_ren", bus.ramREN, 0);
        chk("mid_rst_wen", bus.ramWEN, 0);
        chk("mid_rst_wait", bus.req_wait, 4'hF);

        // Fairness: everyone requesting, RAM completes at once
        cyc();
        bus.req_ren  = 4'hF;
        bus.ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("fair_idle", bus.busy, 0);
            cyc();
            smp();
            wexp = 4'hF;
            wexp[k % 4] = 1'b0;
            chk("fair_owner", bus.owner, 64'(k % 4));
            chk("fair_wait", bus.req_wait, wexp);
            cyc();
        end

        // Single read, ACCESS arrives in the third grant cycle
        bus.req_ren     = 4'b0010;
        bus.req_addr[1] = 32'h40;
        bus.ramstate    = BUSY;
        smp();
        chk("rd_idle_wait", bus.req_wait, 4'hF);
        chk("rd_idle_ren", bus.ramREN, 0);
        cyc();
        smp();
        chk("rd_g1_owner", bus.owner, 1);
        chk("rd_g1_ren", bus.ramREN, 1);
        chk("rd_g1_addr", bus.ramaddr, 32'h40);
        chk("rd_g1_wait", bus.req_wait, 4'hF);
        cyc();
        smp();
        chk("rd_g2_wait", bus.req_wait, 4'hF);
        cyc();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1234_5678;
        smp();
        chk("rd_done_wait", bus.req_wait, 4'b1101);
        chk("rd_load", bus.req_load, 32'h1234_5678);
        cyc();
        bus.req_ren  = '0;
        bus.ramstate = FREE;
        smp();
        chk("rd_after_busy", bus.busy, 0);
        chk("rd_after_wait", bus.req_wait, 4'hF);

        // Write wins over read for the same requester
        cyc();
        bus.req_ren[2]   = 1'b1;
        bus.req_wen[2]   = 1'b1;
        bus.req_addr[2]  = 32'h80;
        bus.req_store[2] = 32'hDEAD_BEEF;
        bus.ramstate     = BUSY;
        smp();
        cyc();
        smp();
        chk("wr_owner", bus.owner, 2);
        chk("wr_wen", bus.ramWEN, 1);
        chk("wr_ren", bus.ramREN, 0);
        chk("wr_store", bus.ramstore, 32'hDEAD_BEEF);
        chk("wr_addr", bus.ramaddr, 32'h80);
        cyc();
        bus.ramstate = ACCESS;
        smp();
        chk("wr_done_wait", bus.req_wait, 4'b1011);
        cyc();
        bus.req_ren  = '0;
        bus.req_wen  = '0;
        bus.ramstate = FREE;
        smp();
        chk("wr_after_busy", bus.busy, 0);

        // RAM error during grant, then a withdrawn request
        cyc();
        bus.req_ren[0] = 1'b1;
        bus.ramstate   = ERROR;
        smp();
        cyc();
        smp();
        chk("er_owner", bus.owner, 0);
        chk("er_wait", bus.req_wait, 4'hF);
        chk("er_err_pre", bus.err, 0);
        cyc();
        smp();
        chk("er_err", bus.err, 1);
        chk("er_busy", bus.busy, 0);
        chk("er_wait_post", bus.req_wait, 4'hF);
        cyc();
        bus.req_ren[0] = 1'b0;
        bus.ramstate   = ACCESS;
        smp();
        chk("wd_busy", bus.busy, 1);
        chk("wd_err_clr", bus.err, 0);
        chk("wd_ren", bus.ramREN, 0);
        chk("wd_wen", bus.ramWEN, 0);
        chk("wd_wait", bus.req_wait, 4'hF);
        cyc();
        bus.ramstate = FREE;
        smp();
        chk("wd_idle", bus.busy, 0);
        chk("wd_no_err", bus.err, 0);

`ifdef RAM_ARB_TIMEOUT_EN
        // RAM stuck BUSY: abort after TO grant cycles, pointer moves past owner
        cyc();
        bus.req_ren[1] = 1'b1;
        bus.ramstate   = BUSY;
        smp();
        for (int g = 0; g < TO; g++) begin
            cyc();
            smp();
            chk("to_busy", bus.busy, 1);
            chk("to_err_low", bus.err, 0);
        end
        cyc();
        bus.req_ren = 4'b1010;
        smp();
        chk("to_err", bus.err, 1);
        chk("to_idle", bus.busy, 0);
        cyc();
        bus.ramstate = ACCESS;
        smp();
        chk("to_next_owner", bus.owner, 3);
        chk("to_next_wait", bus.req_wait, 4'b0111);
        cyc();
        bus.req_ren  = '0;
        bus.ramstate = FREE;
        smp();
`else
        // Without the timeout a stalled grant waits as long as the RAM does
        cyc();
        bus.req_ren[1] = 1'b1;
        bus.ramstate   = BUSY;
        smp();
        for (int g = 0; g < 12; g++) begin
            cyc();
            smp();
            chk("stall_busy", bus.busy, 1);
            chk("stall_err", bus.err, 0);
        end
        cyc();
        bus.ramstate = ACCESS;
        smp();
        chk("stall_done_wait", bus.req_wait, 4'b1101);
        cyc();
        bus.req_ren  = '0;
        bus.ramstate = FREE;
        smp();
        chk("stall_after_busy", bus.busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
